// File: rtl/pe_mq.sv
// Systolic-array PE with a WQ_DEPTH-deep weight queue and weight- or output-stationary dataflow.
// Build option: define PE_ROUND_EN for round-half-up scaling (default truncates toward -inf).
module pe_mq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned WQ_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pe_enabled,
  input  logic                            pe_mode_in,
  input  logic                            pe_valid_in,
  input  logic [DATA_W-1:0]               pe_input_in,
  input  logic [DATA_W-1:0]               pe_psum_in,
  input  logic                            pe_accept_w_in,
  input  logic [DATA_W-1:0]               pe_weight_in,
  input  logic                            pe_switch_in,
  input  logic                            pe_drain_in,
  output logic                            pe_valid_out,
  output logic [DATA_W-1:0]               pe_input_out,
  output logic [DATA_W-1:0]               pe_psum_out,
  output logic                            pe_accept_w_out,
  output logic [DATA_W-1:0]               pe_weight_out,
  output logic                            pe_switch_out,
  output logic                            pe_drain_out,
  output logic [$clog2(WQ_DEPTH+1)-1:0]   pe_wq_count_out,
  output logic                            pe_wq_full_out,
  output logic                            pe_switch_err_out
);

  localparam int unsigned CNT_W  = $clog2(WQ_DEPTH + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = DATA_W + 2;

  localparam logic signed [PROD_W-1:0] WIDE_MAX = (PROD_W'(1) << DATA_W) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] WIDE_MIN = -(PROD_W'(1) << DATA_W);
  localparam logic signed [SUM_W-1:0]  SUM_MAX  = (SUM_W'(1) << (DATA_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0]  SUM_MIN  = -(SUM_W'(1) << (DATA_W - 1));
`ifdef PE_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_W - 1);
`endif

  logic [DATA_W-1:0] wq [WQ_DEPTH];
  logic [DATA_W-1:0] wq_nxt [WQ_DEPTH];
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] acc;

  logic                     full_c;
  logic                     pop_c;
  logic                     push_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] scaled_c;
  logic signed [DATA_W:0]   scaled_clip_c;
  logic [DATA_W-1:0]        mac_ws_c;
  logic [DATA_W-1:0]        mac_acc_c;
  logic [DATA_W-1:0]        mac_zero_c;

  // Saturating add; b is pre-clipped to DATA_W+1 bits so the sum fits DATA_W+2 bits exactly.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                               input logic signed [DATA_W:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'($signed(a)) + SUM_W'(b);
    if (s > SUM_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SUM_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return s[DATA_W-1:0];
  endfunction

  // Product scaling; clipping to DATA_W+1 bits cannot change the saturated result.
  always_comb begin
    prod_c = PROD_W'($signed(pe_input_in)) * PROD_W'($signed(active));
`ifdef PE_ROUND_EN
    scaled_c = (prod_c + RND_HALF) >>> FRAC_W;
`else
    scaled_c = prod_c >>> FRAC_W;
`endif
    if (scaled_c > WIDE_MAX)      scaled_clip_c = {1'b0, {DATA_W{1'b1}}};
    else if (scaled_c < WIDE_MIN) scaled_clip_c = {1'b1, {DATA_W{1'b0}}};
    else                          scaled_clip_c = scaled_c[DATA_W:0];
    mac_ws_c   = sat_add(pe_psum_in, scaled_clip_c);
    mac_acc_c  = sat_add(acc, scaled_clip_c);
    mac_zero_c = sat_add(DATA_W'(0), scaled_clip_c);
  end

  // Weight queue: head at index 0; pop shifts first so a same-cycle push lands behind survivors.
  always_comb begin
    full_c    = (pe_wq_count_out == CNT_W'(WQ_DEPTH));
    pop_c     = pe_switch_in && (pe_wq_count_out != '0);
    push_c    = pe_accept_w_in && !full_c;
    wq_nxt    = wq;
    count_nxt = pe_wq_count_out;
    if (pop_c) begin
      for (int i = 0; i < int'(WQ_DEPTH) - 1; i++) wq_nxt[i] = wq[i+1];
      count_nxt = count_nxt - CNT_W'(1);
    end
    if (push_c) begin
      for (int i = 0; i < int'(WQ_DEPTH); i++)
        if (CNT_W'(i) == count_nxt) wq_nxt[i] = pe_weight_in;
      count_nxt = count_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wq                <= '{default: '0};
      active            <= '0;
      acc               <= '0;
      pe_wq_count_out   <= '0;
      pe_wq_full_out    <= 1'b0;
      pe_valid_out      <= 1'b0;
      pe_input_out      <= '0;
      pe_psum_out       <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_weight_out     <= '0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_switch_err_out <= 1'b0;
    end else if (pe_enabled) begin
      wq                <= wq_nxt;
      pe_wq_count_out   <= count_nxt;
      pe_wq_full_out    <= (count_nxt == CNT_W'(WQ_DEPTH));
      if (pop_c) active <= wq[0];
      pe_accept_w_out   <= pe_accept_w_in && full_c;
      if (pe_accept_w_in && full_c) pe_weight_out <= pe_weight_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
      pe_switch_err_out <= pe_switch_in && !pop_c;
      if (!pe_mode_in) begin
        if (pe_valid_in) begin
          pe_psum_out  <= mac_ws_c;
          pe_input_out <= pe_input_in;
          pe_valid_out <= 1'b1;
        end else begin
          pe_psum_out  <= '0;
          pe_valid_out <= 1'b0;
        end
      end else begin
        if (pe_valid_in) pe_input_out <= pe_input_in;
        if (pe_drain_in) begin
          pe_psum_out  <= acc;
          pe_valid_out <= 1'b1;
          acc          <= pe_valid_in ? mac_zero_c : '0;
        end else begin
          pe_psum_out  <= pe_psum_in;
          pe_valid_out <= 1'b0;
          if (pe_valid_in) acc <= mac_acc_c;
        end
      end
    end else begin
      pe_switch_err_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mq.sv
// Bench for pe_mq: directed scenarios plus randomized traffic against a queue/integer reference model.
module tb_pe_mq;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned WQ_DEPTH = 2;
  localparam int unsigned CNT_W    = $clog2(WQ_DEPTH + 1);

  logic              clk;
  logic              rst, en, mode, valid, accw, sw, dr;
  logic [DATA_W-1:0] inp, psum, w;
  logic              valid_o, accw_o, sw_o, dr_o, full_o, err_o;
  logic [DATA_W-1:0] inp_o, psum_o, wout_o;
  logic [CNT_W-1:0]  cnt_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_act, m_acc;
  logic [DATA_W-1:0] e_psum, e_inp, e_wout;
  int                e_cnt;
  bit                e_valid, e_accw, e_sw, e_dr, e_full, e_err;

  pe_mq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .pe_enabled(en), .pe_mode_in(mode), .pe_valid_in(valid),
    .pe_input_in(inp), .pe_psum_in(psum), .pe_accept_w_in(accw), .pe_weight_in(w),
    .pe_switch_in(sw), .pe_drain_in(dr), .pe_valid_out(valid_o), .pe_input_out(inp_o),
    .pe_psum_out(psum_o), .pe_accept_w_out(accw_o), .pe_weight_out(wout_o),
    .pe_switch_out(sw_o), .pe_drain_out(dr_o), .pe_wq_count_out(cnt_o),
    .pe_wq_full_out(full_o), .pe_switch_err_out(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sx(input logic [DATA_W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint scale(input longint p);
`ifdef PE_ROUND_EN
    return (p + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
`else
    return p >>> FRAC_W;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] sat(input longint v);
    longint lo, hi;
    lo = -(longint'(1) <<< (DATA_W - 1));
    hi = -lo - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    if ($urandom_range(0, 1) == 0) return DATA_W'($urandom);
    return DATA_W'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next-cycle expectations from the current inputs and model state.
  task automatic model();
    longint prod;
    bit     full_now, pop;
    if (!rst) begin
      q.delete(); m_act = '0; m_acc = '0;
      e_psum = '0; e_inp = '0; e_wout = '0; e_cnt = 0;
      e_valid = 0; e_accw = 0; e_sw = 0; e_dr = 0; e_full = 0; e_err = 0;
      return;
    end
    if (!en) begin
      e_err = 0;
      return;
    end
    prod     = scale(sx(inp) * sx(m_act));
    full_now = (q.size() == WQ_DEPTH);
    pop      = sw && (q.size() > 0);
    e_err    = sw && !pop;
    if (pop) m_act = q.pop_front();
    if (accw && !full_now) q.push_back(w);
    e_accw = accw && full_now;
    if (e_accw) e_wout = w;
    e_sw = sw;
    e_dr = dr;
    if (!mode) begin
      if (valid) begin e_psum = sat(sx(psum) + prod); e_inp = inp; e_valid = 1; end
      else begin e_psum = '0; e_valid = 0; end
    end else begin
      if (dr) begin
        e_psum = m_acc; e_valid = 1;
        m_acc = valid ? sat(prod) : '0;
      end else begin
        e_psum = psum; e_valid = 0;
        if (valid) m_acc = sat(sx(m_acc) + prod);
      end
      if (valid) e_inp = inp;
    end
    e_cnt  = q.size();
    e_full = (q.size() == WQ_DEPTH);
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("valid_out", 32'(valid_o), 32'(e_valid));
    chk("input_out", 32'(inp_o), 32'(e_inp));
    chk("psum_out", 32'(psum_o), 32'(e_psum));
    chk("accept_w_out", 32'(accw_o), 32'(e_accw));
    chk("weight_out", 32'(wout_o), 32'(e_wout));
    chk("switch_out", 32'(sw_o), 32'(e_sw));
    chk("drain_out", 32'(dr_o), 32'(e_dr));
    chk("wq_count", 32'(cnt_o), 32'(e_cnt));
    chk("wq_full", 32'(full_o), 32'(e_full));
    chk("switch_err", 32'(err_o), 32'(e_err));
  endtask

  // Empty the queue, push one weight and pop it into the active register.
  task automatic load_active(input logic [DATA_W-1:0] wv);
    for (int k = 0; k < int'(WQ_DEPTH) && q.size() > 0; k++) begin
      sw = 1; step();
    end
    sw = 0; accw = 1; w = wv; step();
    accw = 0; sw = 1; step();
    sw = 0;
  endtask

  initial begin
    rst = 0; en = 1; mode = 0; valid = 0; accw = 0; sw = 0; dr = 0;
    inp = '0; psum = '0; w = '0;
    step();
    chk("reset_count", 32'(cnt_o), 32'd0);
    chk("reset_psum", 32'(psum_o), 32'd0);
    rst = 1;

    // Weight load and forward when full
    accw = 1; w = 16'h0180; step();
    w = 16'h0200; step();
    chk("t1_count2", 32'(cnt_o), 32'd2);
    chk("t1_full", 32'(full_o), 32'd1);
    w = 16'h0300; step();
    chk("t1_fwd_w", 32'(wout_o), 32'h0300);
    chk("t1_fwd_v", 32'(accw_o), 32'd1);
    chk("t1_count_hold", 32'(cnt_o), 32'd2);
    accw = 0;

    // Switch then weight-stationary MAC
    sw = 1; step(); sw = 0;
    chk("t2_count1", 32'(cnt_o), 32'd1);
    valid = 1; inp = 16'h0200; psum = 16'h0080; step();
    chk("t2_psum", 32'(psum_o), 32'h0380);
    chk("t2_valid", 32'(valid_o), 32'd1);
    chk("t2_inp", 32'(inp_o), 32'h0200);
    valid = 0; inp = 16'h1234; step();
    chk("t2_psum0", 32'(psum_o), 32'd0);
    chk("t2_valid0", 32'(valid_o), 32'd0);
    chk("t2_inp_hold", 32'(inp_o), 32'h0200);

    // Saturation and rounding
    load_active(16'h6400);
    valid = 1; inp = 16'h6400; psum = '0; step();
    chk("t3_sat_hi", 32'(psum_o), 32'h7FFF);
    inp = 16'h9C00; step();
    chk("t3_sat_lo", 32'(psum_o), 32'h8000);
    valid = 0;
    load_active(16'h0001);
    valid = 1; inp = 16'h0080; psum = '0; step();
`ifdef PE_ROUND_EN
    chk("t3_round", 32'(psum_o), 32'h0001);
`else
    chk("t3_round", 32'(psum_o), 32'h0000);
`endif
    valid = 0;

    // Switch on empty queue, then switch with push
    sw = 1; step(); sw = 0;
    chk("t4_err1", 32'(err_o), 32'd1);
    step();
    chk("t4_err_pulse", 32'(err_o), 32'd0);
    valid = 1; inp = 16'h0100; psum = '0; step(); valid = 0;
    chk("t4_active_kept", 32'(psum_o), 32'h0001);
    accw = 1; w = 16'h0222; step();
    w = 16'h0333; sw = 1; step();
    accw = 0; sw = 0;
    chk("t4_count_same", 32'(cnt_o), 32'd1);

    // Output-stationary accumulate and drain
    mode = 1;
    load_active(16'h0200);
    valid = 1; psum = 16'h5555;
    inp = 16'h0100; step();
    inp = 16'h0180; step();
    inp = 16'h0040; step();
    valid = 0; dr = 1; step();
    chk("t5_drain", 32'(psum_o), 32'h0580);
    chk("t5_valid", 32'(valid_o), 32'd1);
    chk("t5_drain_out", 32'(dr_o), 32'd1);
    step();
    chk("t5_drain2", 32'(psum_o), 32'h0000);
    dr = 0;

    // Hold while disabled
    en = 0; sw = 1; accw = 1; valid = 1; dr = 1; w = 16'h0777; inp = 16'h0123; step();
    chk("hold_err", 32'(err_o), 32'd0);
    sw = 0; accw = 0; valid = 0; dr = 0; en = 1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      valid = 1'($urandom_range(0, 1));
      accw  = ($urandom_range(0, 2) == 0);
      sw    = ($urandom_range(0, 3) == 0);
      dr    = ($urandom_range(0, 4) == 0);
      inp   = rnd_word();
      psum  = rnd_word();
      w     = rnd_word();
      step();
    end
    en = 1; valid = 0; accw = 0; sw = 0; dr = 0;

    // Reset with full queue and nonzero accumulator
    mode = 1;
    load_active(16'h0100);
    valid = 1; inp = 16'h0100; step(); valid = 0;
    accw = 1; w = 16'h0011; step();
    w = 16'h0022; step(); accw = 0;
    chk("t6_pre_count", 32'(cnt_o), 32'd2);
    rst = 0; step(); rst = 1;
    chk("t6_count", 32'(cnt_o), 32'd0);
    chk("t6_full", 32'(full_o), 32'd0);
    chk("t6_psum", 32'(psum_o), 32'd0);
    chk("t6_inp", 32'(inp_o), 32'd0);
    chk("t6_wout", 32'(wout_o), 32'd0);
    chk("t6_valid", 32'(valid_o), 32'd0);
    dr = 1; step(); dr = 0;
    chk("t6_acc_cleared", 32'(psum_o), 32'd0);
    sw = 1; step(); sw = 0;
    chk("t6_err", 32'(err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mq.md
Name: pe_mq

Overview:
- Parametrised successor to the systolic-array processing element.
- Replaces the fixed two-register weight double-buffer with a WQ_DEPTH-deep weight queue, so several weight tiles can be preloaded ahead of use.
- Adds a selectable dataflow mode: weight-stationary with psum flowing south, or output-stationary with a local accumulator and a chained drain.
- Sits in the systolic array grid. Inputs flow east; weights, psums, switch and drain flow south.

Parameters:
DATA_W, 16, fixed-point word width (signed two's complement)
FRAC_W, 8, fractional bits (Q8.8 at default)
WQ_DEPTH, 2, weight queue entries (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
pe_enabled  in  1  0 = every register holds
pe_mode_in  in  1  0 = weight-stationary, 1 = output-stationary
pe_valid_in  in  1  pe_input_in valid
pe_input_in  in  DATA_W  activation from west
pe_psum_in  in  DATA_W  psum from north
pe_accept_w_in  in  1  pe_weight_in valid
pe_weight_in  in  DATA_W  weight from north
pe_switch_in  in  1  pop queue head into active weight
pe_drain_in  in  1  output-stationary drain request
pe_valid_out  out  1  pe_psum_out valid
pe_input_out  out  DATA_W  activation to east
pe_psum_out  out  DATA_W  psum to south
pe_accept_w_out  out  1  forwarded weight valid
pe_weight_out  out  DATA_W  forwarded weight
pe_switch_out  out  1  registered pe_switch_in
pe_drain_out  out  1  registered pe_drain_in
pe_wq_count_out  out  $clog2(WQ_DEPTH+1)  queue occupancy
pe_wq_full_out  out  1  count == WQ_DEPTH
pe_switch_err_out  out  1  switch requested on empty queue

Behaviour:
- Reset and enable
  - rst low at a clk edge: all outputs 0, queue empty, active weight 0, accumulator 0.
  - All outputs are registered; latency is 1 cycle throughout.
  - pe_enabled=0: no push, pop, MAC or forward; all registers and outputs hold; pe_switch_err_out=0.
- Weight load
  - Full is judged on the count at cycle start.
  - accept_w and not full: push pe_weight_in to tail; pe_accept_w_out <= 0.
  - accept_w and full: no push; pe_weight_out <= pe_weight_in, pe_accept_w_out <= 1.
  - A pop in the same cycle does not make room for the incoming weight; it is still forwarded.
  - pe_weight_out holds when nothing is forwarded.
- Switch
  - pe_switch_out <= pe_switch_in.
  - count>0: active <= head, pop.
  - Push and pop in the same cycle: count unchanged; the new weight lands behind the remaining entries.
  - count==0: active holds; pe_switch_err_out pulses 1 for one cycle.
  - The MAC uses the active weight as it was before the edge.
- Arithmetic
  - prod = pe_input_in*active at 2*DATA_W, signed.
  - Scale prod by shifting right FRAC_W (rounding rule under Optional Feature).
  - Add at DATA_W+2 bits, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Mode 0 (weight-stationary)
  - valid_in: psum_out <= sat(psum_in+prod), input_out <= input_in, valid_out <= 1.
  - Else: psum_out <= 0, valid_out <= 0, input_out holds.
- Mode 1 (output-stationary)
  - valid_in: acc <= sat(acc+prod), input_out <= input_in.
  - drain_in: psum_out <= acc, valid_out <= 1, acc <= 0.
  - drain together with valid_in: psum_out <= old acc, acc <= sat(0+prod).
  - No drain: psum_out <= psum_in, valid_out <= 0.
  - pe_drain_out <= pe_drain_in, so rows drain on successive cycles.
- Mode changes take effect next cycle; the accumulator is never cleared by a mode change.

Optional Feature:
- Macro PE_ROUND_EN.
- Defined: round-half-up, (prod + 2^(FRAC_W-1)) >>> FRAC_W.
- Undefined: truncation, prod >>> FRAC_W (toward -inf).
- Saturation is identical in both builds.

Test Plan:
1. Reset; WQ_DEPTH=2; push 0x0180, then 0x0200 -> count 2, full 1. Push 0x0300 -> next cycle pe_weight_out=0x0300, accept_w_out=1, count stays 2.
2. Switch -> active=0x0180, count 1. Mode 0, valid, input 0x0200, psum 0x0080 -> next cycle psum_out=0x0380, valid_out=1, input_out=0x0200. Next cycle valid=0 -> psum_out=0, valid_out=0, input_out holds 0x0200.
3. Saturation and rounding, mode 0:
   - active 0x6400, input 0x6400 -> psum_out 0x7FFF.
   - input 0x9C00 -> psum_out 0x8000.
   - active 0x0001, input 0x0080, psum 0 -> psum_out 0x0001 with PE_ROUND_EN, 0x0000 without.
4. Empty queue, switch -> switch_err_out=1 for exactly one cycle; active unchanged. Switch together with a push at count 1 -> count stays 1.
5. Mode 1, active 0x0200, valid inputs 0x0100, 0x0180, 0x0040 -> then drain: psum_out=0x0580, valid_out=1, drain_out=1. Second drain -> psum_out=0x0000.
6. Count 2 and acc nonzero; rst low one cycle -> all outputs 0, count 0. A subsequent switch -> switch_err_out=1.
